// File: rtl/wb_scoreboard.sv
// wb_scoreboard: writeback stage in front of the register file.
// It merges single-cycle ALU results with in-order load returns and tracks
// the destination registers of outstanding loads in a small FIFO. The FIFO
// drives per-register pending bits and the issue stall for RAW/WAW hazards.
// ALU results that lose arbitration to a load return are parked in a
// one-entry skid buffer.
// Optional feature: define WB_R0_ZERO_EN to make register 0 hard-wired to
// zero. With it, writes to r0 are consumed but never enabled, and loads to
// r0 are not tracked.
module wb_scoreboard #(
    parameter int RAW      = 3,
    parameter int DW       = 8,
    parameter int LD_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [RAW-1:0] rs_in,
    input  logic [RAW-1:0] rt_in,
    input  logic [RAW-1:0] dst_in,
    output logic           stall_out,
    input  logic           ld_issue_in,
    input  logic           mem_valid_in,
    input  logic [DW-1:0]  mem_data_in,
    input  logic           alu_valid_in,
    input  logic [RAW-1:0] alu_rd_in,
    input  logic [DW-1:0]  alu_data_in,
    output logic           alu_ready_out,
    output logic [RAW-1:0] rd_out,
    output logic           wen_out,
    output logic [DW-1:0]  wrdata_out,
    output logic           err_out
);

    localparam int PW   = $clog2(LD_DEPTH);
    localparam int NREG = 1 << RAW;
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

`ifdef WB_R0_ZERO_EN
    localparam logic R0_ZERO = 1'b1;
`else
    localparam logic R0_ZERO = 1'b0;
`endif

    // Load FIFO: rd tags plus one valid bit per slot, used for the pending bits.
    logic [RAW-1:0]      ld_rd [LD_DEPTH];
    logic [LD_DEPTH-1:0] ld_vld;
    logic [PW:0]         wr_ptr;
    logic [PW:0]         rd_ptr;
    logic                empty;
    logic                full;
    logic                pop;
    logic                push_req;
    logic                push;
    logic                ld_err;
    logic [NREG-1:0]     pending;

    // One-entry skid buffer for ALU results that lose arbitration.
    logic                skid_valid;
    logic [RAW-1:0]      skid_rd;
    logic [DW-1:0]       skid_data;
    logic                skid_load;
    logic                skid_drain;

    // Writeback selection
    logic                alu_acc;
    logic                sel_valid;
    logic [RAW-1:0]      sel_rd;
    logic [DW-1:0]       sel_data;
    logic                wr_commit;

    // The extra pointer bit separates the full state from the empty state.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);

    assign pop      = mem_valid_in & ~empty;
    assign push_req = ld_issue_in & ~(R0_ZERO & (dst_in == {RAW{1'b0}}));
    assign push     = push_req & (~full | pop);
    assign ld_err   = (mem_valid_in & empty) | (push_req & full & ~pop);

    // Ready depends only on registered state, so there is no path from valid.
    assign alu_ready_out = ~skid_valid;
    assign alu_acc       = alu_valid_in & ~skid_valid;

    // Pending bits: OR over every live FIFO entry. r0 is masked when hard-wired.
    always_comb begin
        pending = {NREG{1'b0}};
        for (int i = 0; i < LD_DEPTH; i++) begin
            if (ld_vld[i]) begin
                pending[ld_rd[i]] = 1'b1;
            end else begin
                pending = pending;
            end
        end
        if (R0_ZERO) begin
            pending[0] = 1'b0;
        end else begin
            pending = pending;
        end
    end

    assign stall_out = pending[rs_in] | pending[rt_in] | pending[dst_in] | full;

    // Writeback arbitration: load return first, then the skid entry, then a new ALU result.
    always_comb begin
        sel_valid  = 1'b0;
        sel_rd     = {RAW{1'b0}};
        sel_data   = {DW{1'b0}};
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        if (pop) begin
            sel_valid = 1'b1;
            sel_rd    = ld_rd[rd_ptr[PW-1:0]];
            sel_data  = mem_data_in;
            skid_load = alu_acc;
        end else if (skid_valid) begin
            sel_valid  = 1'b1;
            sel_rd     = skid_rd;
            sel_data   = skid_data;
            skid_drain = 1'b1;
        end else if (alu_acc) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd_in;
            sel_data  = alu_data_in;
        end else begin
            sel_valid = 1'b0;
        end
    end

    assign wr_commit = sel_valid & ~(R0_ZERO & (sel_rd == {RAW{1'b0}}));

    // FIFO pointers and slots. A push to the slot being popped wins, because it is applied last.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= {(PW+1){1'b0}};
            rd_ptr <= {(PW+1){1'b0}};
            ld_vld <= {LD_DEPTH{1'b0}};
            for (int i = 0; i < LD_DEPTH; i++) begin
                ld_rd[i] <= {RAW{1'b0}};
            end
        end else begin
            if (pop) begin
                rd_ptr                  <= rd_ptr + PTR_ONE;
                ld_vld[rd_ptr[PW-1:0]]  <= 1'b0;
            end
            if (push) begin
                wr_ptr                  <= wr_ptr + PTR_ONE;
                ld_rd[wr_ptr[PW-1:0]]   <= dst_in;
                ld_vld[wr_ptr[PW-1:0]]  <= 1'b1;
            end
        end
    end

    // Skid buffer: capture the ALU result that loses to a load; drain it when it is selected.
    always_ff @(posedge clk) begin
        if (reset) begin
            skid_valid <= 1'b0;
            skid_rd    <= {RAW{1'b0}};
            skid_data  <= {DW{1'b0}};
        end else if (skid_load) begin
            skid_valid <= 1'b1;
            skid_rd    <= alu_rd_in;
            skid_data  <= alu_data_in;
        end else if (skid_drain) begin
            skid_valid <= 1'b0;
        end else begin
            skid_valid <= skid_valid;
        end
    end

    // Registered write port. Address and data hold when no write is presented.
    always_ff @(posedge clk) begin
        if (reset) begin
            wen_out    <= 1'b0;
            rd_out     <= {RAW{1'b0}};
            wrdata_out <= {DW{1'b0}};
        end else begin
            wen_out <= wr_commit;
            if (wr_commit) begin
                rd_out     <= sel_rd;
                wrdata_out <= sel_data;
            end
        end
    end

    // Sticky protocol error: a return with no load outstanding, or an issue into a full FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_out <= 1'b0;
        end else if (ld_err) begin
            err_out <= 1'b1;
        end else begin
            err_out <= err_out;
        end
    end

endmodule

// File: tb/tb_wb_scoreboard.sv
// Self-checking bench for wb_scoreboard. Directed scenarios are followed by
// random traffic, all compared against a queue-based reference model.
module tb_wb_scoreboard;

    localparam int D = 4;
`ifdef WB_R0_ZERO_EN
    localparam bit ZERO_EN = 1'b1;
`else
    localparam bit ZERO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] rs_in, rt_in, dst_in, alu_rd_in, rd_out;
    logic       stall_out, ld_issue_in, mem_valid_in, alu_valid_in;
    logic       alu_ready_out, wen_out, err_out;
    logic [7:0] mem_data_in, alu_data_in, wrdata_out;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int q[$];
    bit m_skv;
    int m_skrd, m_skd;
    bit m_wen;
    int m_rd, m_data;
    bit m_err;

    always #5 clk = ~clk;

    wb_scoreboard #(.RAW(3), .DW(8), .LD_DEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .rs_in(rs_in), .rt_in(rt_in), .dst_in(dst_in), .stall_out(stall_out),
        .ld_issue_in(ld_issue_in), .mem_valid_in(mem_valid_in), .mem_data_in(mem_data_in),
        .alu_valid_in(alu_valid_in), .alu_rd_in(alu_rd_in), .alu_data_in(alu_data_in),
        .alu_ready_out(alu_ready_out), .rd_out(rd_out), .wen_out(wen_out),
        .wrdata_out(wrdata_out), .err_out(err_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_pending(int r);
        if (ZERO_EN && r == 0) return 1'b0;
        foreach (q[i]) if (q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: drive inputs, check outputs against the model, then advance the model.
    task automatic step(input logic rst, input logic li, input logic mv, input logic av,
                        input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] dst,
                        input logic [2:0] ard, input logic [7:0] md, input logic [7:0] ad);
        bit full, empty, pop, preq, acc, sv;
        int srd, sd;
        @(negedge clk);
        reset = rst; ld_issue_in = li; mem_valid_in = mv; alu_valid_in = av;
        rs_in = rs; rt_in = rt; dst_in = dst; alu_rd_in = ard;
        mem_data_in = md; alu_data_in = ad;
        #1;
        full  = (q.size() == D);
        empty = (q.size() == 0);
        check("stall", 32'(stall_out),
              32'(m_pending(int'(rs)) | m_pending(int'(rt)) | m_pending(int'(dst)) | full));
        check("alu_ready", 32'(alu_ready_out), 32'(!m_skv));
        check("wen", 32'(wen_out), 32'(m_wen));
        check("rd", 32'(rd_out), 32'(m_rd));
        check("wrdata", 32'(wrdata_out), 32'(m_data));
        check("err", 32'(err_out), 32'(m_err));
        if (rst) begin
            q.delete(); m_skv = 1'b0; m_err = 1'b0;
            m_wen = 1'b0; m_rd = 0; m_data = 0;
        end else begin
            pop  = mv && !empty;
            preq = li && !(ZERO_EN && dst == 3'd0);
            acc  = av && !m_skv;
            if ((mv && empty) || (preq && full && !pop)) m_err = 1'b1;
            sv = 1'b0; srd = 0; sd = 0;
            if (pop) begin
                sv = 1'b1; srd = q.pop_front(); sd = int'(md);
                if (acc) begin
                    m_skv = 1'b1; m_skrd = int'(ard); m_skd = int'(ad);
                end
            end else if (m_skv) begin
                sv = 1'b1; srd = m_skrd; sd = m_skd; m_skv = 1'b0;
            end else if (acc) begin
                sv = 1'b1; srd = int'(ard); sd = int'(ad);
            end
            if (preq && (!full || pop)) q.push_back(int'(dst));
            m_wen = sv && !(ZERO_EN && srd == 0);
            if (m_wen) begin
                m_rd = srd; m_data = sd;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input logic [2:0] rs);
        step(1'b0, 1'b0, 1'b0, 1'b0, rs, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00);
    endtask

    task automatic ld(input logic [2:0] dst);
        step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, dst, 3'd0, 8'h00, 8'h00);
    endtask

    task automatic ret(input logic [7:0] md, input logic [2:0] rs);
        step(1'b0, 1'b0, 1'b1, 1'b0, rs, 3'd0, 3'd0, 3'd0, md, 8'h00);
    endtask

    task automatic rst_cycle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00);
    endtask

    initial begin
        reset = 1'b1; ld_issue_in = 1'b0; mem_valid_in = 1'b0; alu_valid_in = 1'b0;
        rs_in = 3'd0; rt_in = 3'd0; dst_in = 3'd0; alu_rd_in = 3'd0;
        mem_data_in = 8'h00; alu_data_in = 8'h00;
        repeat (2) @(posedge clk);
        q.delete(); m_skv = 1'b0; m_err = 1'b0; m_wen = 1'b0; m_rd = 0; m_data = 0;

        // Reset state, then a plain ALU write
        idle(3'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 3'd3, 8'h00, 8'h5A);
        #1;
        check("tp1_wen", 32'(wen_out), 32'd1);
        check("tp1_rd", 32'(rd_out), 32'd3);
        check("tp1_data", 32'(wrdata_out), 32'h5A);
        check("tp1_ready", 32'(alu_ready_out), 32'd1);

        // A load to r2 stalls readers of r2 until it returns
        ld(3'd2);
        #1;
        check("tp2_stall", 32'(stall_out), 32'd1);
        idle(3'd2);
        ret(8'h11, 3'd2);
        #1;
        check("tp2_wen", 32'(wen_out), 32'd1);
        check("tp2_rd", 32'(rd_out), 32'd2);
        check("tp2_data", 32'(wrdata_out), 32'h11);
        check("tp2_stall_drop", 32'(stall_out), 32'd0);

        // A load return collides with an ALU result, which goes through the skid buffer
        ld(3'd1);
        step(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 3'd0, 3'd0, 3'd4, 8'hAA, 8'h33);
        #1;
        check("tp3_rd1", 32'(rd_out), 32'd1);
        check("tp3_data1", 32'(wrdata_out), 32'hAA);
        check("tp3_ready0", 32'(alu_ready_out), 32'd0);
        idle(3'd0);
        #1;
        check("tp3_rd2", 32'(rd_out), 32'd4);
        check("tp3_data2", 32'(wrdata_out), 32'h33);
        check("tp3_ready1", 32'(alu_ready_out), 32'd1);

        // Fill the FIFO, overflow it, then drain; duplicate r1 stays pending across two returns
        ld(3'd1); ld(3'd1); ld(3'd5); ld(3'd6);
        #1;
        check("tp4_full_stall", 32'(stall_out), 32'd1);
        ld(3'd7);
        #1;
        check("tp4_err", 32'(err_out), 32'd1);
        ret(8'h01, 3'd1);
        ret(8'h02, 3'd1);
        ret(8'h03, 3'd1);
        ret(8'h04, 3'd6);
        idle(3'd6);

        // A return with nothing outstanding; a reset with loads in flight
        rst_cycle();
        ret(8'h55, 3'd0);
        #1;
        check("tp5_err", 32'(err_out), 32'd1);
        check("tp5_wen", 32'(wen_out), 32'd0);
        ld(3'd1); ld(3'd2); ld(3'd3);
        rst_cycle();
        idle(3'd1);
        #1;
        check("tp5_stall_after_rst", 32'(stall_out), 32'd0);
        check("tp5_err_after_rst", 32'(err_out), 32'd0);
        ret(8'h66, 3'd2);
        rst_cycle();

        // ALU write to r0
        step(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 8'h00, 8'hFF);
        #1;
        check("tp6_wen", 32'(wen_out), ZERO_EN ? 32'd0 : 32'd1);
        if (!ZERO_EN) begin
            check("tp6_rd", 32'(rd_out), 32'd0);
            check("tp6_data", 32'(wrdata_out), 32'hFF);
        end

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 1) == 0) ? 1'b1 : 1'b0,
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        end
        idle(3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
